// File: rtl/aes_ced_pkg.sv
// Shared AES CED types, the inverse S-box table and its parity table derived at elaboration.
package aes_ced_pkg;

  localparam int AES_NBYTES = 16;

  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } ced_fsm_e;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic par8(input logic [7:0] b);
    return ^b;
  endfunction

  function automatic logic [255:0] build_par();
    logic [255:0] p;
    p = '0;
    for (int i = 0; i < 256; i++) p[i] = par8(INV_SBOX[i]);
    return p;
  endfunction

  // Stored separately from the S-box so the output check compares against a table, not the live result.
  localparam logic [255:0] INV_SBOX_PAR = build_par();

endpackage

// File: rtl/inv_sbox_par.sv
// Combinational inverse S-box lookup with its table-predicted output parity.
// Zero latency, no flow control.
module inv_sbox_par
  import aes_ced_pkg::*;
(
  input  logic [7:0] data,
  output logic [7:0] sub,
  output logic       pred_par
);

  assign sub      = INV_SBOX[data];
  assign pred_par = INV_SBOX_PAR[data];

endmodule

// File: rtl/inv_sub_bytes_ced.sv
// Inverse SubBytes with per-byte parity CED, LANES S-boxes per cycle; block done NCYC cycles after accept.
// One block in flight; holds result in DONE until OutReady_SI. INV_SBOX_FAULT_INJ_EN adds FaultInj_DI.
module inv_sub_bytes_ced
  import aes_ced_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         Clk_CI,
  input  logic         Rst_RI,
  input  logic         InValid_SI,
  output logic         InReady_SO,
  input  logic [127:0] State_DI,
  input  logic [15:0]  InParity_DI,
`ifdef INV_SBOX_FAULT_INJ_EN
  input  logic [7:0]   FaultInj_DI,
`endif
  output logic         OutValid_SO,
  input  logic         OutReady_SI,
  output logic [127:0] State_DO,
  output logic [15:0]  OutParity_DO,
  output logic         Err_SO,
  output logic         ErrSticky_SO,
  input  logic         ErrClr_SI
);

  localparam int NCYC = AES_NBYTES / LANES;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  ced_fsm_e   state_q, state_d;
  aes_state_t in_state_q, out_state_q;
  logic [15:0]  in_par_q, out_par_q;
  logic [CW-1:0] cnt_q;
  logic err_acc_q, err_q, sticky_q;
  logic accept, last, blk_err, in_ready, out_valid;

  logic [LANES-1:0] lane_err;
  logic [LANES-1:0] lane_par;
  logic [7:0]       lane_res [LANES];
  logic [3:0]       lane_idx [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0] data, sub, res;
    logic       pred;

    assign lane_idx[l] = 4'(int'(cnt_q) * LANES + l);
    assign data        = in_state_q[{lane_idx[l], 3'b000} +: 8];

    inv_sbox_par u_sbox (
      .data     (data),
      .sub      (sub),
      .pred_par (pred)
    );

    if (l == 0) begin : g_fault
`ifdef INV_SBOX_FAULT_INJ_EN
      assign res = sub ^ FaultInj_DI;
`else
      assign res = sub;
`endif
    end else begin : g_plain
      assign res = sub;
    end

    assign lane_res[l] = res;
    assign lane_par[l] = pred;
    assign lane_err[l] = (par8(data) != in_par_q[lane_idx[l]]) | (par8(res) != pred);
  end

  assign blk_err = err_acc_q | (|lane_err);

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    last      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (InValid_SI) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == CW'(NCYC - 1)) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (OutReady_SI) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      in_state_q  <= '0;
      in_par_q    <= '0;
      cnt_q       <= '0;
      err_acc_q   <= 1'b0;
      out_state_q <= '0;
      out_par_q   <= '0;
      err_q       <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      if (accept) begin
        in_state_q <= State_DI;
        in_par_q   <= InParity_DI;
        cnt_q      <= '0;
        err_acc_q  <= 1'b0;
      end
      if (state_q == RUN) begin
        cnt_q     <= cnt_q + CW'(1);
        err_acc_q <= blk_err;
        for (int l = 0; l < LANES; l++) begin
          out_state_q[{lane_idx[l], 3'b000} +: 8] <= lane_res[l];
          out_par_q[lane_idx[l]]                  <= lane_par[l];
        end
      end
      if (last) err_q <= blk_err;
      // A new error on the DONE-entry edge beats a coincident clear.
      if (last && blk_err)  sticky_q <= 1'b1;
      else if (ErrClr_SI)   sticky_q <= 1'b0;
    end
  end

  assign InReady_SO   = in_ready;
  assign OutValid_SO  = out_valid;
  assign State_DO     = out_state_q;
  assign OutParity_DO = out_par_q;
  assign Err_SO       = err_q;
  assign ErrSticky_SO = sticky_q;

endmodule

// File: tb/tb_inv_sub_bytes_ced.sv
// Scoreboard bench for inv_sub_bytes_ced; the reference inverse S-box is rebuilt from GF(2^8) arithmetic.
module tb_inv_sub_bytes_ced;

  localparam int LANES = 4;
  localparam int NCYC  = 16 / LANES;

  logic         Clk_CI = 1'b0;
  logic         Rst_RI = 1'b1;
  logic         InValid_SI = 1'b0;
  logic         InReady_SO;
  logic [127:0] State_DI = '0;
  logic [15:0]  InParity_DI = '0;
  logic         OutValid_SO;
  logic         OutReady_SI = 1'b1;
  logic [127:0] State_DO;
  logic [15:0]  OutParity_DO;
  logic         Err_SO;
  logic         ErrSticky_SO;
  logic         ErrClr_SI = 1'b0;
  logic [7:0]   fault_inj = 8'h00;

  always #5 Clk_CI = ~Clk_CI;

  inv_sub_bytes_ced #(.LANES(LANES)) dut (
    .Clk_CI       (Clk_CI),
    .Rst_RI       (Rst_RI),
    .InValid_SI   (InValid_SI),
    .InReady_SO   (InReady_SO),
    .State_DI     (State_DI),
    .InParity_DI  (InParity_DI),
`ifdef INV_SBOX_FAULT_INJ_EN
    .FaultInj_DI  (fault_inj),
`endif
    .OutValid_SO  (OutValid_SO),
    .OutReady_SI  (OutReady_SI),
    .State_DO     (State_DO),
    .OutParity_DO (OutParity_DO),
    .Err_SO       (Err_SO),
    .ErrSticky_SO (ErrSticky_SO),
    .ErrClr_SI    (ErrClr_SI)
  );

  typedef struct packed {
    logic [127:0] st;
    logic [15:0]  par;
    logic         err;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] ref_inv [256];
  int         n_chk = 0;
  int         n_bad = 0;

  task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // Forward S-box = affine(GF inverse); invert it to get the reference table.
  task automatic build_ref();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      ref_inv[s] = 8'(x);
    end
  endtask

  function automatic logic [15:0] good_par(input logic [127:0] st);
    logic [15:0] p;
    for (int i = 0; i < 16; i++) p[i] = ^st[8*i +: 8];
    return p;
  endfunction

  function automatic exp_t model(input logic [127:0] st, input logic [15:0] par, input logic [7:0] f);
    exp_t e;
    logic [7:0] b, s;
    e = '0;
    for (int i = 0; i < 16; i++) begin
      b = st[8*i +: 8];
      s = ref_inv[b];
      e.par[i] = ^s;
      if ((^b) != par[i]) e.err = 1'b1;
      if (i % LANES == 0) begin
        s = s ^ f;
        if (^f) e.err = 1'b1;
      end
      e.st[8*i +: 8] = s;
    end
    return e;
  endfunction

  task automatic send(input logic [127:0] st, input logic [15:0] par, input bit track);
    int w;
    w = 0;
    State_DI = st; InParity_DI = par; InValid_SI = 1'b1;
    @(negedge Clk_CI);
    while (!InReady_SO && w < 100) begin
      @(negedge Clk_CI);
      w++;
    end
    if (!InReady_SO) chk_eq("accept_timeout", InReady_SO, 1'b1);
    if (track) sb_q.push_back(model(st, par, fault_inj));
    @(posedge Clk_CI); #1;
    InValid_SI = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge Clk_CI);
      n++;
    end while (!OutValid_SO && n < 100);
    if (!OutValid_SO) chk_eq("valid_timeout", OutValid_SO, 1'b1);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < 200) begin
      @(negedge Clk_CI);
      w++;
    end
    if (sb_q.size() != 0) begin
      chk_eq("drain_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
    @(posedge Clk_CI); #1;
  endtask

  always @(negedge Clk_CI) begin
    if (!Rst_RI && OutValid_SO && OutReady_SI) begin
      exp_t e;
      if (sb_q.size() == 0) chk_eq("spurious_out", OutValid_SO, 1'b0);
      else begin
        e = sb_q.pop_front();
        chk_eq("out_state", State_DO, e.st);
        chk_eq("out_par", OutParity_DO, e.par);
        chk_eq("out_err", Err_SO, e.err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] blk, rnd;
    logic [15:0]  p;
    int n;
    build_ref();

    repeat (3) @(posedge Clk_CI);
    #1 Rst_RI = 1'b0;
    @(negedge Clk_CI);
    chk_eq("rst_in_ready", InReady_SO, 1'b1);
    chk_eq("rst_out_valid", OutValid_SO, 1'b0);
    chk_eq("rst_state", State_DO, '0);
    chk_eq("rst_par", OutParity_DO, '0);
    chk_eq("rst_err", Err_SO, 1'b0);
    chk_eq("rst_sticky", ErrSticky_SO, 1'b0);
    @(posedge Clk_CI); #1;

    // All-0x63 block maps to all zeros.
    send({16{8'h63}}, 16'h0000, 1'b1);
    wait_valid(n);
    chk_eq("t1_latency", n, NCYC + 1);
    chk_eq("t1_state", State_DO, '0);
    chk_eq("t1_err", Err_SO, 1'b0);
    drain();

    // Byte i = i with correct parity.
    for (int i = 0; i < 16; i++) blk[8*i +: 8] = 8'(i);
    send(blk, good_par(blk), 1'b1);
    wait_valid(n);
    chk_eq("t2_b0", State_DO[7:0], 8'h52);
    chk_eq("t2_b1", State_DO[15:8], 8'h09);
    chk_eq("t2_b2", State_DO[23:16], 8'h6a);
    chk_eq("t2_par10", OutParity_DO[1:0], 2'b01);
    drain();

    // Input parity error on byte 5, then sticky clear, then clear coincident with a new error.
    send({16{8'h63}}, 16'h0020, 1'b1);
    wait_valid(n);
    chk_eq("t3_err", Err_SO, 1'b1);
    chk_eq("t3_sticky_set", ErrSticky_SO, 1'b1);
    drain();
    ErrClr_SI = 1'b1;
    @(posedge Clk_CI); #1;
    ErrClr_SI = 1'b0;
    @(negedge Clk_CI);
    chk_eq("t3_sticky_clr", ErrSticky_SO, 1'b0);
    @(posedge Clk_CI); #1;
    ErrClr_SI = 1'b1;
    send({16{8'h63}}, 16'h0020, 1'b1);
    wait_valid(n);
    ErrClr_SI = 1'b0;
    chk_eq("t3_set_wins", ErrSticky_SO, 1'b1);
    drain();

    // Output stall in DONE with input offered.
    OutReady_SI = 1'b0;
    for (int i = 0; i < 16; i++) blk[8*i +: 8] = 8'(8'h30 + i);
    send(blk, good_par(blk), 1'b1);
    wait_valid(n);
    @(posedge Clk_CI); #1;
    InValid_SI = 1'b1;
    State_DI = ~blk;
    InParity_DI = good_par(~blk);
    repeat (10) begin
      @(negedge Clk_CI);
      chk_eq("t4_hold_state", State_DO, sb_q[0].st);
      chk_eq("t4_in_ready", InReady_SO, 1'b0);
      chk_eq("t4_out_valid", OutValid_SO, 1'b1);
    end
    @(posedge Clk_CI); #1;
    InValid_SI = 1'b0;
    OutReady_SI = 1'b1;
    drain();

    // Reset in RUN cycle 2 aborts the block.
    send({16{8'h11}}, good_par({16{8'h11}}), 1'b0);
    @(posedge Clk_CI);
    @(posedge Clk_CI); #1;
    Rst_RI = 1'b1;
    @(posedge Clk_CI); #1;
    Rst_RI = 1'b0;
    @(negedge Clk_CI);
    chk_eq("t5_out_valid", OutValid_SO, 1'b0);
    chk_eq("t5_in_ready", InReady_SO, 1'b1);
    chk_eq("t5_state", State_DO, '0);
    chk_eq("t5_par", OutParity_DO, '0);
    chk_eq("t5_err", Err_SO, 1'b0);
    chk_eq("t5_sticky", ErrSticky_SO, 1'b0);
    @(posedge Clk_CI); #1;
    send({16{8'hff}}, 16'h0000, 1'b1);
    wait_valid(n);
    chk_eq("t5_ff", State_DO, {16{8'h7d}});
    drain();

    // Random back-to-back blocks, some with a corrupted parity bit.
    for (int k = 0; k < 8; k++) begin
      rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
      p = good_par(rnd);
      if (k % 3 == 0) p = p ^ (16'h0001 << $urandom_range(0, 15));
      send(rnd, p, 1'b1);
    end
    drain();

`ifdef INV_SBOX_FAULT_INJ_EN
    fault_inj = 8'h01;
    send({16{8'h63}}, 16'h0000, 1'b1);
    wait_valid(n);
    chk_eq("t6_b0", State_DO[7:0], 8'h01);
    chk_eq("t6_err", Err_SO, 1'b1);
    drain();
    fault_inj = 8'h00;
    send({16{8'h63}}, 16'h0000, 1'b1);
    wait_valid(n);
    chk_eq("t6_clean_err", Err_SO, 1'b0);
    drain();
`endif

    repeat (5) @(negedge Clk_CI);
    chk_eq("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
